alarm_unit: RTL
===============

Name: alarm_unit

Overview:
- Downstream consumer of the time-of-day counter: compares the live BCD time against a user-set alarm time (HH:MM).
- Drives a pulsed buzzer output, supports snooze and auto-timeout.
- Owns its own alarm-set mode, using the same select/increment button scheme as time-setting.
- Sits between the time-of-day digits and the board buzzer/LED/7-seg mux.

Parameters:
- RING_SECS, 60, seconds of ringing before automatic return to IDLE
- SNOOZE_SECS, 300, seconds spent in SNOOZE before ringing again
- CNT_W, 9, width of the internal seconds counter; must hold max(RING_SECS, SNOOZE_SECS)

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- sec_tick  input  1  one-cycle pulse, once per second (the counter's inc strobe)
- secU, secT, minU, minT, hrU, hrT  input  4 each  live BCD time digits
- alarm_en  input  1  level; 0 disables triggering and silences immediately
- set_alarm  input  1  level; high = alarm-set mode
- switch_select  input  1  debounced one-cycle pulse; rotate selected digit
- increment  input  1  debounced one-cycle pulse; increment selected digit
- snooze  input  1  debounced one-cycle pulse
- alm_minU, alm_minT, alm_hrU, alm_hrT  output  4 each  stored alarm digits
- alm_sel  output  4  one-hot selected digit {hrT,hrU,minT,minU}; 0 outside SET
- ringing  output  1  high in RINGING
- buzz  output  1  ringing AND tone_q (1 Hz beep pattern)

Behaviour:
- Reset values:
  - alarm digits 00:00
  - state IDLE, alm_sel 0000, counter 0, tone_q 0, ringing 0, buzz 0
  - match_q = 1, so a reset at 00:00:00 never rings
- Match:
  - match = (hrT,hrU,minT,minU == alarm digits) && secT==0 && secU==0
  - match_q registers match every cycle
  - trigger = match && !match_q && alarm_en
- States (enum, 2 bits): IDLE, SET, RINGING, SNOOZE.
- Priority each cycle: set_alarm > !alarm_en > per-state rules.
  - set_alarm=1 from any state -> SET next cycle; alm_sel loads 0001 on entry.
  - alarm_en=0 in RINGING or SNOOZE -> IDLE next cycle; counter cleared.
- IDLE:
  - trigger -> RINGING; counter=0, tone_q=1.
  - buzz first asserts the cycle after the matching time value appears.
- SET:
  - switch_select: alm_sel rotates left (0001->0010->0100->1000->0001).
  - increment: selected digit +1 with wrap.
    - minU 9->0; minT 5->0; hrT 2->0.
    - hrU 9->0 when hrT<2; hrU 3->0 when hrT==2.
    - If hrT becomes 2 with hrU>3, hrU clears to 0 in the same cycle.
  - Simultaneous switch_select and increment: increment applies to the old selection; rotation takes effect next cycle.
  - No triggering in SET.
  - set_alarm falls -> IDLE; alm_sel=0; match_q is not forced.
- RINGING:
  - On each sec_tick: counter+1 and tone_q toggles.
  - counter reaches RING_SECS-1 on a tick -> IDLE.
  - snooze pulse -> SNOOZE; counter=0; buzz drops next cycle.
  - snooze has priority over a same-cycle timeout tick.
- SNOOZE:
  - On each sec_tick: counter+1.
  - counter reaches SNOOZE_SECS-1 on a tick -> RINGING; counter=0, tone_q=1.
  - Extra snooze pulses are ignored.
  - A fresh trigger while in SNOOZE is ignored.
- Widths: digit adds are 4-bit with explicit wrap compare, never relying on overflow. Counter is CNT_W-bit saturating-free (bounded by the compares).
- Time digits change only on sec_tick edges; no synchronisation is required, since the unit shares clk with the counter.
- Reset mid-ring: the asynchronous reset returns to IDLE at once and buzz deasserts asynchronously.

Decomposition:
- Package alarm_pkg:
  - alarm_state_t enum
  - digit max constants (MIN_U_MAX=9, MIN_T_MAX=5, HR_T_MAX=2, HR_U_MAX_24=3)
  - one-hot select constants SEL_MINU..SEL_HRT
- Sub-module alarm_time_reg:
  - holds the four alarm digits, applies the increment/wrap rules
  - inputs: clk, resetn, inc, sel
  - outputs: the digits
- alarm_unit holds the FSM, match edge detect, seconds counter, tone and select rotation.

Test Plan:
1. Reset, then hold set_alarm; pulse select twice (alm_sel=0100), increment 7 times; release -> alarm digits 07:00, alm_sel=0000.
2. alarm_en=1, drive time 06:59:59 then 07:00:00 -> ringing=1 next cycle; buzz toggles each sec_tick; after 60 ticks -> IDLE, buzz=0. Hold 07:00:xx -> no re-trigger.
3. Ringing; pulse snooze -> SNOOZE, buzz=0; after 300 sec_ticks -> RINGING again; drop alarm_en -> IDLE next cycle.
4. In SET with hrT=1, hrU=9: increment hrT -> hrT=2, hrU=0. Then increment hrU 4 times -> hrU 0,1,2,3,0. Increment hrT -> 0.
5. Same-cycle snooze and final RINGING tick -> SNOOZE, not IDLE. Same-cycle select and increment on minU=9 -> minU=0, alm_sel=0010 next cycle.
6. Assert resetn=0 while RINGING at 00:00:00 -> outputs at reset values immediately. Release with time still 00:00:00, alarm_en=1 -> no ring (match_q=1).

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm unit.
// Covers the FSM state type, the digit wrap limits and the one-hot digit-select codes.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET     = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam logic [3:0] MIN_U_MAX   = 4'd9;
  localparam logic [3:0] MIN_T_MAX   = 4'd5;
  localparam logic [3:0] HR_T_MAX    = 4'd2;
  localparam logic [3:0] HR_U_MAX    = 4'd9;
  localparam logic [3:0] HR_U_MAX_24 = 4'd3;

  localparam logic [3:0] SEL_MINU = 4'b0001;
  localparam logic [3:0] SEL_MINT = 4'b0010;
  localparam logic [3:0] SEL_HRU  = 4'b0100;
  localparam logic [3:0] SEL_HRT  = 4'b1000;

  // Wrap is done by an explicit compare against the limit, never by overflow.
  function automatic logic [3:0] nextDigit(input logic [3:0] digit, input logic [3:0] maxVal);
    return (digit >= maxVal) ? 4'd0 : digit + 4'd1;
  endfunction

  function automatic logic [3:0] rotateSel(input logic [3:0] sel);
    return {sel[2:0], sel[3]};
  endfunction

endpackage

// File: rtl/alarm_time_reg.sv
// Stored alarm time (HH:MM, BCD).
// The selected digit is incremented with 24-hour wrap rules.
module alarm_time_reg
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       inc,
  input  logic [3:0] sel,
  output logic [3:0] minU,
  output logic [3:0] minT,
  output logic [3:0] hrU,
  output logic [3:0] hrT
);

  logic [3:0] hrTNext;
  logic [3:0] hrUMax;

  assign hrTNext = nextDigit(hrT, HR_T_MAX);
  assign hrUMax  = (hrT == HR_T_MAX) ? HR_U_MAX_24 : HR_U_MAX;

  // Moving into the 20s hours must not leave an illegal 24..29 hour behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      minU <= 4'd0;
      minT <= 4'd0;
      hrU  <= 4'd0;
      hrT  <= 4'd0;
    end else if (inc) begin
      case (sel)
        SEL_MINU: minU <= nextDigit(minU, MIN_U_MAX);
        SEL_MINT: minT <= nextDigit(minT, MIN_T_MAX);
        SEL_HRU:  hrU  <= nextDigit(hrU, hrUMax);
        SEL_HRT: begin
          hrT <= hrTNext;
          if ((hrTNext == HR_T_MAX) && (hrU > HR_U_MAX_24)) begin
            hrU <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alarm_unit.sv
// Alarm clock controller: compares live time with the stored alarm.
// Rings with a 1 Hz beep, handles snooze and auto-timeout, and owns its own set mode.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int CNT_W       = 9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sec_tick,
  input  logic [3:0] secU,
  input  logic [3:0] secT,
  input  logic [3:0] minU,
  input  logic [3:0] minT,
  input  logic [3:0] hrU,
  input  logic [3:0] hrT,
  input  logic       alarm_en,
  input  logic       set_alarm,
  input  logic       switch_select,
  input  logic       increment,
  input  logic       snooze,
  output logic [3:0] alm_minU,
  output logic [3:0] alm_minT,
  output logic [3:0] alm_hrU,
  output logic [3:0] alm_hrT,
  output logic [3:0] alm_sel,
  output logic       ringing,
  output logic       buzz
);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

  alarm_state_t     state;
  logic [3:0]       almSel;
  logic [CNT_W-1:0] counter;
  logic             toneQ;
  logic             ringingQ;
  logic             matchQ;
  logic             match;
  logic             trigger;
  logic             incPulse;

  assign match = (hrT == alm_hrT) && (hrU == alm_hrU) &&
                 (minT == alm_minT) && (minU == alm_minU) &&
                 (secT == 4'd0) && (secU == 4'd0);
  assign trigger  = match && !matchQ && alarm_en;
  assign incPulse = (state == SET) && set_alarm && increment;

  alarm_time_reg timeReg (
    .clk    (clk),
    .resetn (resetn),
    .inc    (incPulse),
    .sel    (almSel),
    .minU   (alm_minU),
    .minT   (alm_minT),
    .hrU    (alm_hrU),
    .hrT    (alm_hrT)
  );

  // matchQ resets high so that powering up exactly at the alarm time never rings.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      almSel   <= 4'b0000;
      counter  <= '0;
      toneQ    <= 1'b0;
      ringingQ <= 1'b0;
      matchQ   <= 1'b1;
    end else begin
      matchQ <= match;
      if (set_alarm) begin
        state    <= SET;
        counter  <= '0;
        toneQ    <= 1'b0;
        ringingQ <= 1'b0;
        if (state != SET) begin
          almSel <= SEL_MINU;
        end else if (switch_select) begin
          almSel <= rotateSel(almSel);
        end
      end else if (!alarm_en && ((state == RINGING) || (state == SNOOZE))) begin
        state    <= IDLE;
        counter  <= '0;
        toneQ    <= 1'b0;
        ringingQ <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trigger) begin
              state    <= RINGING;
              counter  <= '0;
              toneQ    <= 1'b1;
              ringingQ <= 1'b1;
            end
          end
          SET: begin
            state  <= IDLE;
            almSel <= 4'b0000;
          end
          // Snooze wins over a timeout tick arriving in the same cycle.
          RINGING: begin
            if (snooze) begin
              state    <= SNOOZE;
              counter  <= '0;
              toneQ    <= 1'b0;
              ringingQ <= 1'b0;
            end else if (sec_tick) begin
              if (counter == RING_LAST) begin
                state    <= IDLE;
                counter  <= '0;
                toneQ    <= 1'b0;
                ringingQ <= 1'b0;
              end else begin
                counter <= counter + 1'b1;
                toneQ   <= ~toneQ;
              end
            end
          end
          SNOOZE: begin
            if (sec_tick) begin
              if (counter == SNOOZE_LAST) begin
                state    <= RINGING;
                counter  <= '0;
                toneQ    <= 1'b1;
                ringingQ <= 1'b1;
              end else begin
                counter <= counter + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign alm_sel = almSel;
  assign ringing = ringingQ;
  assign buzz    = ringingQ & toneQ;

endmodule
